// File: rtl/pe1_writeback_pkg.sv
// Shared definitions for the PE1 write-back stage: butterfly modes, FSM states,
// default pipeline latencies and mode helpers.
package pe1_writeback_pkg;

  localparam int ADDR_W_DEF    = 6;
  localparam int DATA_W_DEF    = 24;
  localparam int LAT_K2NTT_DEF = 8;
  localparam int LAT_K4NTT_DEF = 8;
  localparam int LAT_KINTT_DEF = 22;
  localparam int LAT_DNTT_DEF  = 8;
  localparam int LAT_DINTT_DEF = 8;
  localparam int MAX_LAT_DEF   = 22;

  // {KD_mode, sel_1, sel_0}; 3'b101 and 3'b111 have no encoding
  typedef enum logic [2:0] {
    MODE_K2NTT  = 3'b000,
    MODE_K4NTT  = 3'b001,
    MODE_K2INTT = 3'b010,
    MODE_K4INTT = 3'b011,
    MODE_DNTT   = 3'b100,
    MODE_DINTT  = 3'b110
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Dilithium has no radix-4 variant
  function automatic logic is_legal(input logic [2:0] mode_bits);
    return !(mode_bits[2] && mode_bits[0]);
  endfunction

  // Radix-2 Kyber only produces a meaningful PE1_out1
  function automatic logic is_k2(input mode_e mode);
    return (mode == MODE_K2NTT) || (mode == MODE_K2INTT);
  endfunction

endpackage

// File: rtl/pe1_writeback_if.sv
// Read-side and write-side bus between the bank read logic, PE1 and the
// write-back stage.
interface pe1_writeback_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 24
);

  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr0;
  logic [ADDR_W-1:0] rd_addr1;
  logic              rd_last;
  logic [DATA_W-1:0] PE1_out1;
  logic [DATA_W-1:0] PE1_out2;

  logic              wr_en0;
  logic              wr_en1;
  logic [ADDR_W-1:0] wr_addr0;
  logic [ADDR_W-1:0] wr_addr1;
  logic [DATA_W-1:0] wr_data0;
  logic [DATA_W-1:0] wr_data1;

  modport master (
    output rd_valid, rd_addr0, rd_addr1, rd_last, PE1_out1, PE1_out2,
    input  wr_en0, wr_en1, wr_addr0, wr_addr1, wr_data0, wr_data1
  );

  modport slave (
    input  rd_valid, rd_addr0, rd_addr1, rd_last, PE1_out1, PE1_out2,
    output wr_en0, wr_en1, wr_addr0, wr_addr1, wr_data0, wr_data1
  );

endinterface

// File: rtl/pe1_writeback_addr_delay_line.sv
// Shift register of {valid, addr0, addr1} tracking operand addresses through PE1.
// Entries retire at the runtime-selected tap so a later, longer tap never sees them.
module pe1_writeback_addr_delay_line #(
  parameter int ADDR_W  = 6,
  parameter int MAX_LAT = 22,
  parameter int LAT_W   = $clog2(MAX_LAT + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push_valid,
  input  logic [ADDR_W-1:0]                push_addr0,
  input  logic [ADDR_W-1:0]                push_addr1,
  input  logic [LAT_W-1:0]                 tap_sel,
  output logic                             tap_valid,
  output logic [ADDR_W-1:0]                tap_addr0,
  output logic [ADDR_W-1:0]                tap_addr1,
  output logic [MAX_LAT-1:0]               ent_valid,
  output logic [MAX_LAT-1:0][ADDR_W-1:0]   ent_addr0,
  output logic [MAX_LAT-1:0][ADDR_W-1:0]   ent_addr1
);

  logic [MAX_LAT-1:0]             valid_reg;
  logic [MAX_LAT-1:0][ADDR_W-1:0] addr0_reg;
  logic [MAX_LAT-1:0][ADDR_W-1:0] addr1_reg;
  logic                           tap_in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      addr0_reg <= '0;
      addr1_reg <= '0;
    end else begin
      valid_reg[0] <= push_valid;
      addr0_reg[0] <= push_addr0;
      addr1_reg[0] <= push_addr1;
      for (int k = 1; k < MAX_LAT; k++) begin
        valid_reg[k] <= valid_reg[k-1] && (tap_sel != LAT_W'(k - 1));
        addr0_reg[k] <= addr0_reg[k-1];
        addr1_reg[k] <= addr1_reg[k-1];
      end
    end
  end

  // tap_sel wraps to all-ones before the first start; treat that as no tap
  assign tap_in_range = (tap_sel < LAT_W'(MAX_LAT));
  assign tap_valid    = tap_in_range && valid_reg[tap_sel];
  assign tap_addr0    = tap_in_range ? addr0_reg[tap_sel] : '0;
  assign tap_addr1    = tap_in_range ? addr1_reg[tap_sel] : '0;

  assign ent_valid = valid_reg;
  assign ent_addr0 = addr0_reg;
  assign ent_addr1 = addr1_reg;

endmodule

// File: rtl/pe1_writeback.sv
// Write-back stage after PE1: delays read addresses by the mode latency, pairs them
// with PE1 results for in-place bank writes, tracks completion and flags RAW hazards.
module pe1_writeback
  import pe1_writeback_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int LAT_K2NTT = LAT_K2NTT_DEF,
  parameter int LAT_K4NTT = LAT_K4NTT_DEF,
  parameter int LAT_KINTT = LAT_KINTT_DEF,
  parameter int LAT_DNTT  = LAT_DNTT_DEF,
  parameter int LAT_DINTT = LAT_DINTT_DEF,
  parameter int MAX_LAT   = MAX_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              KD_mode,
  input  logic              sel_1,
  input  logic              sel_0,
  pe1_writeback_if.slave    bus,
  output logic              busy,
  output logic              done,
  output logic              hazard,
  output logic              mode_err
);

  localparam int LAT_W = $clog2(MAX_LAT + 1);
  localparam int CNT_W = $clog2(MAX_LAT + 2);

  state_e                         state_reg;
  mode_e                          mode_reg;
  logic [LAT_W-1:0]               lat_reg;
  logic [CNT_W-1:0]               outstanding_reg;
  logic [CNT_W-1:0]               outstanding_next;
  logic                           busy_reg, done_reg, hazard_reg, mode_err_reg;
  logic                           wr_en0_reg, wr_en1_reg;
  logic [ADDR_W-1:0]              wr_addr0_reg, wr_addr1_reg, wb_addr1_reg;
  logic [DATA_W-1:0]              wr_data0_reg, wr_data1_reg;

  logic [2:0]                     mode_in;
  logic                           push;
  logic [LAT_W-1:0]               tap_sel;
  logic                           tap_valid;
  logic [ADDR_W-1:0]              tap_addr0, tap_addr1;
  logic [MAX_LAT-1:0]             ent_valid;
  logic [MAX_LAT-1:0][ADDR_W-1:0] ent_addr0, ent_addr1;
  logic [MAX_LAT:0]               hit;
  logic                           any_hit;

  function automatic logic [LAT_W-1:0] lat_of(input mode_e mode);
    case (mode)
      MODE_K2NTT:               return LAT_W'(LAT_K2NTT);
      MODE_K4NTT:               return LAT_W'(LAT_K4NTT);
      MODE_K2INTT, MODE_K4INTT: return LAT_W'(LAT_KINTT);
      MODE_DNTT:                return LAT_W'(LAT_DNTT);
      MODE_DINTT:               return LAT_W'(LAT_DINTT);
      default:                  return LAT_W'(LAT_K2NTT);
    endcase
  endfunction

  function automatic logic addr_hit(input logic [ADDR_W-1:0] ra0, input logic [ADDR_W-1:0] ra1,
                                    input logic [ADDR_W-1:0] ea0, input logic [ADDR_W-1:0] ea1);
    return (ra0 == ea0) || (ra0 == ea1) || (ra1 == ea0) || (ra1 == ea1);
  endfunction

  assign mode_in          = {KD_mode, sel_1, sel_0};
  assign push             = bus.rd_valid && (state_reg == ST_RUN);
  assign tap_sel          = lat_reg - LAT_W'(1);
  assign outstanding_next = outstanding_reg + CNT_W'(push) - CNT_W'(wr_en0_reg);

  pe1_writeback_addr_delay_line #(
    .ADDR_W  (ADDR_W),
    .MAX_LAT (MAX_LAT),
    .LAT_W   (LAT_W)
  ) u_delay_line (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (push),
    .push_addr0 (bus.rd_addr0),
    .push_addr1 (bus.rd_addr1),
    .tap_sel    (tap_sel),
    .tap_valid  (tap_valid),
    .tap_addr0  (tap_addr0),
    .tap_addr1  (tap_addr1),
    .ent_valid  (ent_valid),
    .ent_addr0  (ent_addr0),
    .ent_addr1  (ent_addr1)
  );

  // In-flight set = every live delay-line entry plus the one being written now
  genvar gi;
  generate
    for (gi = 0; gi < MAX_LAT; gi++) begin : g_hit
      assign hit[gi] = ent_valid[gi] &&
                       addr_hit(bus.rd_addr0, bus.rd_addr1, ent_addr0[gi], ent_addr1[gi]);
    end
  endgenerate
  assign hit[MAX_LAT] = wr_en0_reg &&
                        addr_hit(bus.rd_addr0, bus.rd_addr1, wr_addr0_reg, wb_addr1_reg);
  assign any_hit = |hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      mode_reg        <= MODE_K2NTT;
      lat_reg         <= '0;
      outstanding_reg <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      hazard_reg      <= 1'b0;
      mode_err_reg    <= 1'b0;
      wr_en0_reg      <= 1'b0;
      wr_en1_reg      <= 1'b0;
      wr_addr0_reg    <= '0;
      wr_addr1_reg    <= '0;
      wb_addr1_reg    <= '0;
      wr_data0_reg    <= '0;
      wr_data1_reg    <= '0;
    end else begin
      // PE1 results line up with the tap cycle; the write issues one cycle later
      wr_en0_reg <= tap_valid;
      wr_en1_reg <= tap_valid && !is_k2(mode_reg);
      if (tap_valid) begin
        wr_addr0_reg <= tap_addr0;
        wr_data0_reg <= bus.PE1_out1;
        wb_addr1_reg <= tap_addr1;
      end
      if (tap_valid && !is_k2(mode_reg)) begin
        wr_addr1_reg <= tap_addr1;
        wr_data1_reg <= bus.PE1_out2;
      end

      outstanding_reg <= outstanding_next;
      done_reg        <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            hazard_reg <= 1'b0;
            if (is_legal(mode_in)) begin
              mode_reg     <= mode_e'(mode_in);
              lat_reg      <= lat_of(mode_e'(mode_in));
              mode_err_reg <= 1'b0;
              busy_reg     <= 1'b1;
              state_reg    <= ST_RUN;
            end else begin
              mode_err_reg <= 1'b1;
            end
          end
          if (bus.rd_valid) begin
            hazard_reg <= 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.rd_valid) begin
            if (any_hit) begin
              hazard_reg <= 1'b1;
            end
            if (bus.rd_last) begin
              state_reg <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (bus.rd_valid) begin
            hazard_reg <= 1'b1;
          end
          if (outstanding_next == '0) begin
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.rd_valid) begin
            hazard_reg <= 1'b1;
          end
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.wr_en0   = wr_en0_reg;
  assign bus.wr_en1   = wr_en1_reg;
  assign bus.wr_addr0 = wr_addr0_reg;
  assign bus.wr_addr1 = wr_addr1_reg;
  assign bus.wr_data0 = wr_data0_reg;
  assign bus.wr_data1 = wr_data1_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign hazard       = hazard_reg;
  assign mode_err     = mode_err_reg;

endmodule

// File: tb/tb_pe1_writeback.sv
// Directed and random stimulus for pe1_writeback, checked each cycle against a
// scoreboard of pending writes derived from the read timestamps and mode latencies.
module tb_pe1_writeback;
  import pe1_writeback_pkg::*;

  localparam int AW  = 6;
  localparam int DW  = 24;
  localparam int INF = 1 << 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, KD_mode = 1'b0, sel_1 = 1'b0, sel_0 = 1'b0;
  logic busy, done, hazard, mode_err;

  pe1_writeback_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  pe1_writeback #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .KD_mode  (KD_mode),
    .sel_1    (sel_1),
    .sel_0    (sel_0),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .hazard   (hazard),
    .mode_err (mode_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          rc;
    int          due;
    int          tap;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
  } ent_t;

  ent_t          pend[$];
  logic [DW-1:0] h1 [0:4095];
  logic [DW-1:0] h2 [0:4095];
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;

  bit            m_active = 1'b0;
  int            m_start = 0, m_last = 0, m_done = 0;
  logic [2:0]    m_mode = 3'b000;
  bit            m_haz = 1'b0, m_err = 1'b0;
  logic [AW-1:0] m_wa0 = '0, m_wa1 = '0;
  logic [DW-1:0] m_wd0 = '0, m_wd1 = '0;

  function automatic int lat_of(input logic [2:0] m);
    case (m)
      3'b000, 3'b001, 3'b100, 3'b110: return 8;
      3'b010, 3'b011:                 return 22;
      default:                        return 0;
    endcase
  endfunction

  function automatic bit legal(input logic [2:0] m);
    return (m != 3'b101) && (m != 3'b111);
  endfunction

  function automatic bit k2(input logic [2:0] m);
    return (m == 3'b000) || (m == 3'b010);
  endfunction

  function automatic bit busy_at(input int t);
    return m_active && (t > m_start) && (t <= m_done);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    bit en0;
    bit en1;
    en0 = 1'b0;
    while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
    for (int i = 0; i < pend.size(); i++) begin
      if (pend[i].due == cyc) begin
        en0   = 1'b1;
        m_wa0 = pend[i].a0;
        m_wd0 = h1[pend[i].tap];
        if (!k2(m_mode)) begin
          m_wa1 = pend[i].a1;
          m_wd1 = h2[pend[i].tap];
        end
      end
    end
    en1 = en0 && !k2(m_mode);
    check("wr_en0",   32'(bus.wr_en0),   32'(en0));
    check("wr_en1",   32'(bus.wr_en1),   32'(en1));
    check("wr_addr0", 32'(bus.wr_addr0), 32'(m_wa0));
    check("wr_addr1", 32'(bus.wr_addr1), 32'(m_wa1));
    check("wr_data0", 32'(bus.wr_data0), 32'(m_wd0));
    check("wr_data1", 32'(bus.wr_data1), 32'(m_wd1));
    check("busy",     32'(busy),         32'(busy_at(cyc)));
    check("done",     32'(done),         32'(m_active && cyc == m_done));
    check("hazard",   32'(hazard),       32'(m_haz));
    check("mode_err", 32'(mode_err),     32'(m_err));
    if (en0)
      $display("wr cyc=%0d a0=%0d a1=%0d d0=%h d1=%h en1=%0d", cyc, m_wa0, m_wa1, m_wd0, m_wd1, en1);
  endtask

  task automatic tick(input bit st, input logic [2:0] md, input bit rv,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1, input bit last);
    logic [DW-1:0] p1, p2;
    int            lat;
    p1 = DW'($urandom);
    p2 = DW'($urandom);
    start = st;
    {KD_mode, sel_1, sel_0} = md;
    bus.rd_valid = rv;
    bus.rd_addr0 = a0;
    bus.rd_addr1 = a1;
    bus.rd_last  = last;
    bus.PE1_out1 = p1;
    bus.PE1_out2 = p2;
    h1[cyc] = p1;
    h2[cyc] = p2;
    if (st && !busy_at(cyc)) begin
      m_haz = 1'b0;
      if (legal(md)) begin
        m_active = 1'b1;
        m_mode   = md;
        m_start  = cyc;
        m_last   = INF;
        m_done   = INF;
        m_err    = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
    if (rv) begin
      if (m_active && cyc > m_start && cyc <= m_last) begin
        lat = lat_of(m_mode);
        for (int i = 0; i < pend.size(); i++) begin
          if (pend[i].rc < cyc && pend[i].due >= cyc &&
              (a0 == pend[i].a0 || a0 == pend[i].a1 || a1 == pend[i].a0 || a1 == pend[i].a1))
            m_haz = 1'b1;
        end
        pend.push_back('{rc: cyc, due: cyc + lat + 1, tap: cyc + lat, a0: a0, a1: a1});
        if (last) begin
          m_last = cyc;
          m_done = cyc + lat + 2;
        end
      end else begin
        m_haz = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 3'b000, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input bit last);
    tick(1'b0, 3'b000, 1'b1, a0, a1, last);
  endtask

  task automatic go(input logic [2:0] md);
    tick(1'b1, md, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    start = 1'b0;
    bus.rd_valid = 1'b0;
    bus.rd_last  = 1'b0;
    #2;
    pend.delete();
    m_active = 1'b0;
    m_haz = 1'b0;
    m_err = 1'b0;
    m_wa0 = '0; m_wa1 = '0; m_wd0 = '0; m_wd1 = '0;
    check_all();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      check_all();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] modes [6];
    logic [2:0] md;
    int         n, k;
    modes = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b110};
    bus.rd_valid = 1'b0;
    bus.rd_addr0 = '0;
    bus.rd_addr1 = '0;
    bus.rd_last  = 1'b0;
    bus.PE1_out1 = '0;
    bus.PE1_out2 = '0;
    #1;
    reset_pulse();

    // K4NTT: 16 back-to-back reads
    go(3'b001);
    for (int i = 0; i < 16; i++) rd(AW'(i), AW'(i + 16), i == 15);
    idle(14);

    // K2INTT: only PE1_out1 written, 23-cycle read-to-write
    go(3'b010);
    for (int i = 0; i < 4; i++) rd(AW'(4 * i), AW'(4 * i + 2), i == 3);
    idle(28);

    // DINTT single read
    go(3'b110);
    rd(6'd7, 6'd9, 1'b1);
    idle(14);

    // illegal mode then a legal start
    go(3'b101);
    idle(3);
    go(3'b000);
    rd(6'd1, 6'd2, 1'b1);
    idle(12);

    // RAW hazard within a stage, then protocol hazard in IDLE
    go(3'b000);
    rd(6'd5, 6'd40, 1'b0);
    idle(2);
    rd(6'd5, 6'd41, 1'b1);
    idle(12);
    rd(6'd3, 6'd4, 1'b0);
    idle(1);
    go(3'b100);
    rd(6'd10, 6'd11, 1'b1);
    idle(12);

    // random stages with narrow address range to provoke hazards
    for (int s = 0; s < 6; s++) begin
      md = modes[$urandom_range(0, 5)];
      n  = $urandom_range(1, 12);
      go(md);
      k = 0;
      while (k < n) begin
        if ($urandom_range(0, 3) != 0) begin
          rd(AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)), k == n - 1);
          k++;
        end else begin
          idle(1);
        end
      end
      idle(lat_of(md) + 5);
    end

    // reset mid-DRAIN with writes in flight
    go(3'b001);
    for (int i = 0; i < 5; i++) rd(AW'(20 + i), AW'(30 + i), i == 4);
    idle(3);
    reset_pulse();
    idle(15);
    go(3'b110);
    rd(6'd1, 6'd2, 1'b1);
    idle(14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
